// File: rtl/cpu_sequencer.sv
// MSP430 instruction-cycle sequencer: decodes Format I/II/jump words, steps addressing modes and interrupt entry.
// Optional build macro NMI_EN adds an edge-triggered, unmaskable nmi input with vector 16'hFFFC.
module cpu_sequencer #(
  parameter logic [15:0] RST_VEC = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
`ifdef NMI_EN
  input  logic        nmi,
`endif
  input  logic [15:0] mdb_in,
  input  logic        gie,
  input  logic        irq,
  input  logic [15:0] irq_vec,
  input  logic        jmp_cond,
  output logic        IF,
  output logic        IdxF,
  output logic        SPF,
  output logic        INTACK,
  output logic        Ex,
  output logic        RW,
  output logic        IW6,
  output logic [3:0]  srcA,
  output logic [3:0]  dstA,
  output logic        srcInc,
  output logic        dstInc,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  mab_sel,
  output logic [1:0]  mdb_sel,
  output logic        res_sel,
  output logic        src_idx_ld,
  output logic        dst_idx_ld,
  output logic        op_src_ld,
  output logic        op_dst_ld,
  output logic [15:0] vec_addr,
  output logic [15:0] iw,
  output logic        irq_ack
);

  typedef enum logic [4:0] {
    S_RST_VEC, S_FETCH, S_SRC_IDX, S_SRC_RD, S_DST_IDX, S_DST_RD, S_EXEC,
    S_WB_MEM, S_PUSH_SP, S_CALL_PC, S_POP_SR, S_POP_PC,
    S_INT_SP1, S_INT_WPC, S_INT_SP2, S_INT_WSR, S_INT_VEC
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] iw_q, iw_d;

  // In FETCH the word is still on the bus; afterwards it lives in iw_q.
  logic [15:0] dw;
  logic        is_jmp, is_f1, is_f2, f2_single, is_push, is_call, is_reti, is_mov;
  logic        ad, src_skip, mem_dst, no_rw_op, int_take, use_nmi;
  logic [3:0]  opc, src_reg;
  logic [2:0]  f2op;
  logic [1:0]  as_m;
  state_t      bnd, after_src;

  assign dw        = (state_q == S_FETCH) ? mdb_in : iw_q;
  assign opc       = dw[15:12];
  assign f2op      = dw[9:7];
  assign is_jmp    = (dw[15:13] == 3'b001);
  assign is_f2     = (dw[15:10] == 6'b000100);
  assign is_f1     = (opc >= 4'd4);
  assign f2_single = is_f2 && (f2op <= 3'd3);
  assign is_push   = is_f2 && (f2op == 3'd4);
  assign is_call   = is_f2 && (f2op == 3'd5);
  assign is_reti   = is_f2 && (f2op == 3'd6);
  assign is_mov    = is_f1 && (opc == 4'd4);
  assign no_rw_op  = is_f1 && ((opc == 4'd9) || (opc == 4'd11));
  assign ad        = dw[7];
  assign as_m      = dw[5:4];
  assign src_reg   = is_f1 ? dw[11:8] : dw[3:0];
  // Register mode and constant-generator encodings need no memory operand.
  assign src_skip  = (as_m == 2'b00) || (src_reg == 4'd3) || ((src_reg == 4'd2) && as_m[1]);
  assign mem_dst   = (is_f1 && ad) || (f2_single && !src_skip);
  assign after_src = is_f1 ? (ad ? S_DST_IDX : S_EXEC)
                           : ((is_push || is_call) ? S_PUSH_SP : S_EXEC);

`ifdef NMI_EN
  logic nmi_prev_q, nmi_pend_q, nmi_sel_q;
  logic nmi_pend_d, nmi_sel_d;

  assign int_take   = (irq && gie) || nmi_pend_q;
  assign use_nmi    = nmi_sel_q;
  assign nmi_pend_d = (nmi_pend_q && !((state_q == S_INT_VEC) && nmi_sel_q)) || (nmi && !nmi_prev_q);
  assign nmi_sel_d  = (state_d == S_INT_SP1) ? nmi_pend_q : nmi_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_sel_q  <= 1'b0;
    end else begin
      nmi_prev_q <= nmi;
      nmi_pend_q <= nmi_pend_d;
      nmi_sel_q  <= nmi_sel_d;
    end
  end
`else
  assign int_take = irq && gie;
  assign use_nmi  = 1'b0;
`endif

  assign bnd = int_take ? S_INT_SP1 : S_FETCH;
  assign iw  = rst ? 16'h0000 : iw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST_VEC;
      iw_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      iw_q    <= iw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    iw_d       = iw_q;
    IF         = 1'b0;
    IdxF       = 1'b0;
    SPF        = 1'b0;
    INTACK     = 1'b0;
    Ex         = 1'b0;
    RW         = 1'b0;
    IW6        = 1'b0;
    srcA       = 4'd0;
    dstA       = 4'd0;
    srcInc     = 1'b0;
    dstInc     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mab_sel    = 3'd0;
    mdb_sel    = 2'd0;
    res_sel    = 1'b0;
    src_idx_ld = 1'b0;
    dst_idx_ld = 1'b0;
    op_src_ld  = 1'b0;
    op_dst_ld  = 1'b0;
    vec_addr   = 16'h0000;
    irq_ack    = 1'b0;
    if (rst) begin
      state_d = S_RST_VEC;
    end else begin
      IW6  = iw_q[6];
      srcA = src_reg;
      dstA = dw[3:0];
      case (state_q)
        S_RST_VEC: begin
          IW6      = 1'b0;
          mem_rd   = 1'b1;
          mab_sel  = 3'd4;
          vec_addr = RST_VEC;
          INTACK   = 1'b1;
          state_d  = S_FETCH;
        end
        S_FETCH: begin
          mem_rd = 1'b1;
          IF     = 1'b1;
          iw_d   = mdb_in;
          if (is_jmp)
            state_d = S_EXEC;
          else if (is_reti)
            state_d = S_POP_SR;
          else if (is_f1 || f2_single || is_push || is_call)
            state_d = src_skip ? after_src : ((as_m == 2'b01) ? S_SRC_IDX : S_SRC_RD);
          else
            state_d = bnd;
        end
        S_SRC_IDX: begin
          mem_rd     = 1'b1;
          IdxF       = 1'b1;
          src_idx_ld = 1'b1;
          state_d    = S_SRC_RD;
        end
        S_SRC_RD: begin
          mem_rd    = 1'b1;
          mab_sel   = 3'd1;
          op_src_ld = 1'b1;
          srcInc    = (as_m == 2'b11);
          state_d   = after_src;
        end
        S_DST_IDX: begin
          mem_rd     = 1'b1;
          IdxF       = 1'b1;
          dst_idx_ld = 1'b1;
          state_d    = is_mov ? S_EXEC : S_DST_RD;
        end
        S_DST_RD: begin
          mem_rd    = 1'b1;
          mab_sel   = 3'd2;
          op_dst_ld = 1'b1;
          state_d   = S_EXEC;
        end
        S_EXEC: begin
          if (is_jmp) begin
            dstA    = 4'd0;
            RW      = jmp_cond;
            state_d = bnd;
          end else begin
            Ex      = !is_mov;
            RW      = !mem_dst && !no_rw_op;
            state_d = mem_dst ? S_WB_MEM : bnd;
          end
        end
        S_WB_MEM: begin
          mem_wr = 1'b1;
          if (is_push || is_call) begin
            IW6     = 1'b0;
            mab_sel = 3'd3;
            mdb_sel = is_call ? 2'd1 : 2'd0;
          end else begin
            mab_sel = is_f2 ? 3'd1 : 3'd2;
          end
          state_d = is_call ? S_CALL_PC : bnd;
        end
        S_PUSH_SP: begin
          IW6     = 1'b0;
          SPF     = 1'b1;
          state_d = S_WB_MEM;
        end
        S_CALL_PC: begin
          IW6     = 1'b0;
          dstA    = 4'd0;
          RW      = 1'b1;
          state_d = bnd;
        end
        S_POP_SR, S_POP_PC: begin
          IW6     = 1'b0;
          mem_rd  = 1'b1;
          mab_sel = 3'd3;
          dstA    = (state_q == S_POP_SR) ? 4'd2 : 4'd0;
          RW      = 1'b1;
          res_sel = 1'b1;
          srcA    = 4'd1;
          srcInc  = 1'b1;
          state_d = (state_q == S_POP_SR) ? S_POP_PC : bnd;
        end
        // Interrupt entry: push PC, push SR, then load the vector.
        S_INT_SP1, S_INT_SP2: begin
          IW6     = 1'b0;
          SPF     = 1'b1;
          state_d = (state_q == S_INT_SP1) ? S_INT_WPC : S_INT_WSR;
        end
        S_INT_WPC, S_INT_WSR: begin
          IW6     = 1'b0;
          mem_wr  = 1'b1;
          mab_sel = 3'd3;
          mdb_sel = (state_q == S_INT_WPC) ? 2'd1 : 2'd2;
          state_d = (state_q == S_INT_WPC) ? S_INT_SP2 : S_INT_VEC;
        end
        S_INT_VEC: begin
          IW6      = 1'b0;
          mem_rd   = 1'b1;
          mab_sel  = 3'd4;
          vec_addr = use_nmi ? 16'hFFFC : irq_vec;
          INTACK   = 1'b1;
          irq_ack  = !use_nmi;
          state_d  = S_FETCH;
        end
        default: state_d = S_RST_VEC;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle expected strobes are queued and compared against the DUT.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nmi = 1'b0;
  logic [15:0] mdb_in = 16'h0000;
  logic        gie = 1'b0, irq = 1'b0, jmp_cond = 1'b0;
  logic [15:0] irq_vec = 16'h0000;
  logic        IF, IdxF, SPF, INTACK, Ex, RW, IW6, srcInc, dstInc, mem_rd, mem_wr, res_sel;
  logic        src_idx_ld, dst_idx_ld, op_src_ld, op_dst_ld, irq_ack;
  logic [3:0]  srcA, dstA;
  logic [2:0]  mab_sel;
  logic [1:0]  mdb_sel;
  logic [15:0] vec_addr, iw;

  cpu_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef NMI_EN
    .nmi(nmi),
`endif
    .mdb_in(mdb_in), .gie(gie), .irq(irq), .irq_vec(irq_vec), .jmp_cond(jmp_cond),
    .IF(IF), .IdxF(IdxF), .SPF(SPF), .INTACK(INTACK), .Ex(Ex), .RW(RW), .IW6(IW6),
    .srcA(srcA), .dstA(dstA), .srcInc(srcInc), .dstInc(dstInc),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mab_sel(mab_sel), .mdb_sel(mdb_sel), .res_sel(res_sel),
    .src_idx_ld(src_idx_ld), .dst_idx_ld(dst_idx_ld), .op_src_ld(op_src_ld), .op_dst_ld(op_dst_ld),
    .vec_addr(vec_addr), .iw(iw), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       f_if, f_idx, f_spf, intack, ex, rw, sinc, rd, wr, ack, res;
    logic [2:0] mab;
    logic [1:0] mdb;
    logic [3:0] ld;   // {src_idx_ld, dst_idx_ld, op_src_ld, op_dst_ld}
  } strb_t;

  typedef struct packed {
    strb_t       s;
    logic        chk_dst;
    logic [3:0]  dsta;
    logic        chk_vec;
    logic [15:0] vec;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   stepn  = 0;

  function automatic exp_t z();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_fetch();
    exp_t e = z();
    e.s.f_if = 1'b1; e.s.rd = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_vec(input logic [15:0] v, input logic ack);
    exp_t e = z();
    e.s.rd = 1'b1; e.s.mab = 3'd4; e.s.intack = 1'b1; e.s.ack = ack;
    e.chk_vec = 1'b1; e.vec = v;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic ex, input logic rw, input logic [3:0] d);
    exp_t e = z();
    e.s.ex = ex; e.s.rw = rw; e.chk_dst = 1'b1; e.dsta = d;
    return e;
  endfunction

  function automatic exp_t e_srcrd(input logic inc);
    exp_t e = z();
    e.s.rd = 1'b1; e.s.mab = 3'd1; e.s.ld = 4'b0010; e.s.sinc = inc;
    return e;
  endfunction

  function automatic exp_t e_dstidx();
    exp_t e = z();
    e.s.rd = 1'b1; e.s.f_idx = 1'b1; e.s.ld = 4'b0100;
    return e;
  endfunction

  function automatic exp_t e_dstrd();
    exp_t e = z();
    e.s.rd = 1'b1; e.s.mab = 3'd2; e.s.ld = 4'b0001;
    return e;
  endfunction

  function automatic exp_t e_wr(input logic [2:0] mab, input logic [1:0] mdb);
    exp_t e = z();
    e.s.wr = 1'b1; e.s.mab = mab; e.s.mdb = mdb;
    return e;
  endfunction

  function automatic exp_t e_spf();
    exp_t e = z();
    e.s.f_spf = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_pop(input logic [3:0] d);
    exp_t e = z();
    e.s.rd = 1'b1; e.s.mab = 3'd3; e.s.rw = 1'b1; e.s.res = 1'b1; e.s.sinc = 1'b1;
    e.chk_dst = 1'b1; e.dsta = d;
    return e;
  endfunction

  // Queue the cycle's expectation, let the combinational outputs settle, then compare.
  task automatic step(input exp_t e);
    exp_t  x;
    strb_t o;
    q.push_back(e);
    #1;
    x = q.pop_front();
    stepn++;
    o = '{f_if: IF, f_idx: IdxF, f_spf: SPF, intack: INTACK, ex: Ex, rw: RW, sinc: srcInc,
          rd: mem_rd, wr: mem_wr, ack: irq_ack, res: res_sel, mab: mab_sel, mdb: mdb_sel,
          ld: {src_idx_ld, dst_idx_ld, op_src_ld, op_dst_ld}};
    ntests++;
    assert (o === x.s) else begin
      nfail++;
      $error("FAIL step%0d strobes: got %h expected %h", stepn, o, x.s);
    end
    if (x.chk_dst) begin
      ntests++;
      assert (dstA === x.dsta) else begin
        nfail++;
        $error("FAIL step%0d dstA: got %0d expected %0d", stepn, dstA, x.dsta);
      end
    end
    if (x.chk_vec) begin
      ntests++;
      assert (vec_addr === x.vec) else begin
        nfail++;
        $error("FAIL step%0d vec_addr: got %h expected %h", stepn, vec_addr, x.vec);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_iw(input logic [15:0] want);
    ntests++;
    assert (iw === want) else begin
      nfail++;
      $error("FAIL step%0d iw: got %h expected %h", stepn, iw, want);
    end
  endtask

  initial begin
    // Reset: strobes quiet, iw cleared.
    @(negedge clk);
    check_iw(16'h0000);
    step(z());
    rst = 1'b0; mdb_in = 16'hC000;
    step(e_vec(16'hFFFE, 1'b0));

    // MOV R4,R5
    mdb_in = 16'h4405; step(e_fetch());
    check_iw(16'h4405);
    step(e_exec(1'b0, 1'b1, 4'd5));

    // ADD @R4+,2(R5)
    mdb_in = 16'h54B5; step(e_fetch());
    step(e_srcrd(1'b1));
    step(e_dstidx());
    step(e_dstrd());
    step(e_exec(1'b1, 1'b0, 4'd5));
    step(e_wr(3'd2, 2'd0));

    // JNE not taken, then taken
    mdb_in = 16'h2001; jmp_cond = 1'b0; step(e_fetch());
    step(e_exec(1'b0, 1'b0, 4'd0));
    jmp_cond = 1'b1; step(e_fetch());
    step(e_exec(1'b0, 1'b1, 4'd0));
    jmp_cond = 1'b0;

    // irq at the MOV boundary; dropping irq mid-entry must not abort it
    mdb_in = 16'h4405; step(e_fetch());
    irq = 1'b1; gie = 1'b1; irq_vec = 16'hFFF2;
    step(e_exec(1'b0, 1'b1, 4'd5));
    irq = 1'b0;
    step(e_spf());
    step(e_wr(3'd3, 2'd1));
    step(e_spf());
    step(e_wr(3'd3, 2'd2));
    step(e_vec(16'hFFF2, 1'b1));

    // Reset in DST_RD suppresses the pending write
    mdb_in = 16'h54B5; step(e_fetch());
    step(e_srcrd(1'b1));
    step(e_dstidx());
    rst = 1'b1; step(z());
    rst = 1'b0; step(e_vec(16'hFFFE, 1'b0));
    check_iw(16'h0000);

    // CALL R5
    mdb_in = 16'h1285; step(e_fetch());
    step(e_spf());
    step(e_wr(3'd3, 2'd1));
    step(e_exec(1'b0, 1'b1, 4'd0));

    // RETI with irq masked: no entry at the boundary
    irq = 1'b1; gie = 1'b0;
    mdb_in = 16'h1300; step(e_fetch());
    step(e_pop(4'd2));
    step(e_pop(4'd0));
    mdb_in = 16'h0000; step(e_fetch());
    irq = 1'b0;
    step(e_fetch());

`ifdef NMI_EN
    // NMI edge with gie=0 is taken at the next boundary
    mdb_in = 16'h4405; nmi = 1'b1; step(e_fetch());
    step(e_exec(1'b0, 1'b1, 4'd5));
    step(e_spf());
    step(e_wr(3'd3, 2'd1));
    step(e_spf());
    step(e_wr(3'd3, 2'd2));
    step(e_vec(16'hFFFC, 1'b0));
    mdb_in = 16'h0000; step(e_fetch());
    step(e_fetch());
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
